// File: rtl/dec3to8_fifo.sv
// 3-to-8 one-hot decoder behind a small input FIFO and a single registered output stage.
// Codes are stored raw; decoding (and the en gate) happens as a code moves into the output register.
module dec3to8_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       in_valid,
   input  logic [2:0] in_code,
   output logic       in_ready,
   output logic       out_valid,
   output logic [7:0] out_y,
   input  logic       out_ready,
   output logic       full,
   output logic       empty,
   output logic [7:0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   OCC_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   OCC_FULL = (AW+1)'(DEPTH);

   logic [2:0]    mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0]   occ;
   logic          push, pop;

   assign full     = (occ == OCC_FULL);
   assign empty    = (occ == '0);
   assign in_ready = !full;

   // A full FIFO refuses writes even when the head is popped the same cycle.
   assign push = in_valid && !full;
   assign pop  = !empty && (!out_valid || out_ready);

   // Storage carries no reset; the pointers and occupancy define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_code;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         if (push && !pop)      occ <= occ + OCC_ONE;
         else if (pop && !push) occ <= occ - OCC_ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_y     <= 8'h00;
      end else if (pop) begin
         out_valid <= 1'b1;
         out_y     <= en ? (8'h01 << mem[rd_ptr]) : 8'h00;
      end else if (out_ready) begin
         // Drained with nothing behind it: drop valid, keep the last word visible.
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                        count <= 8'h00;
      else if (out_valid && out_ready && count != 8'hFF) count <= count + 8'd1;
   end

endmodule

// File: doc/dec3to8_fifo.md
DEC3TO8_FIFO -- requirements
Module: dec3to8_fifo

Interface
REQ-001 Parameter: DEPTH, 4, input FIFO entries; the value SHALL be a power of two and at least 2.
REQ-002 Port: clk, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-003 Port: rst, input, 1, reset; it SHALL be asynchronous and active-high.
REQ-004 Port: en, input, 1, decode enable, sampled at output-stage load.
REQ-005 Port: in_valid, input, 1, the producer has a code on in_code.
REQ-006 Port: in_code, input, 3, binary code to decode.
REQ-007 Port: in_ready, output, 1, the block can accept a code this cycle.
REQ-008 Port: out_valid, output, 1, out_y holds a decoded word.
REQ-009 Port: out_y, output, 8, decoded one-hot word.
REQ-010 Port: out_ready, input, 1, the consumer accepts out_y this cycle.
REQ-011 Port: full, output, 1, the FIFO holds DEPTH entries.
REQ-012 Port: empty, output, 1, the FIFO holds 0 entries.
REQ-013 Port: count, output, 8, number of completed output handshakes, saturating.

Function
REQ-014 Input handshake: a code SHALL be written to the FIFO tail only when in_valid=1 and in_ready=1 at a clock edge.
REQ-015 in_ready SHALL equal !full combinationally.
- When full, no write occurs, even if a pop happens in the same cycle.
REQ-016 in_code SHALL be ignored when in_valid=0.
REQ-017 FIFO storage:
- Circular buffer with read and write pointers of log2(DEPTH) bits that wrap modulo DEPTH.
- Occupancy counter of log2(DEPTH)+1 bits.
- full = (occupancy == DEPTH); empty = (occupancy == 0).
REQ-018 Output stage: one register pair (out_valid, out_y).
- Load condition: !empty and (out_valid=0 or out_ready=1).
- On load: pop the FIFO head and set out_valid=1.
REQ-019 Loaded value: out_y SHALL be 8'h01 << code when en=1, and 8'h00 when en=0, with en sampled at the load edge.
- Exactly one bit is set when en=1.
REQ-020 If out_valid=1, out_ready=1 and the FIFO is empty, out_valid SHALL clear to 0 at the next edge; out_y keeps its last value.
REQ-021 If out_valid=1 and out_ready=0, out_valid and out_y SHALL hold unchanged.
REQ-022 Push and pop in the same cycle SHALL leave occupancy unchanged; both pointers advance.
REQ-023 Latency: a code accepted at edge N with the FIFO empty and the output stage empty or draining SHALL show out_valid=1 with its decoded out_y after edge N+1.
- No combinational path from in_code to out_y.
REQ-024 Ordering: codes SHALL emerge in acceptance order, with no loss or duplication.
REQ-025 count SHALL increment by 1 on each edge where out_valid=1 and out_ready=1.
- It saturates at 8'hFF and never wraps.
REQ-026 Sustained throughput SHALL be one code per cycle when out_ready is held at 1.

Reset
REQ-027 While rst=1, the block SHALL immediately force:
- out_valid=0, out_y=8'h00, count=8'h00;
- both pointers and occupancy to 0, so empty=1, full=0, in_ready=1.
REQ-028 Reset asserted mid-operation SHALL discard all queued and presented codes with no output handshake.
- The first code accepted after release follows REQ-023.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Single code, en=1, out_ready=1: in_code=3'd5 accepted at edge N -> out_y=8'h20, out_valid=1 after edge N+1, count=1 after edge N+2.
- Disabled decode: en=0, in_code=3'd7 -> out_y=8'h00, out_valid=1.
- Sweep: codes 0..7 back-to-back, out_ready=1 -> out_y sequence 01,02,04,08,10,20,40,80 on consecutive cycles, count=8.
- Backpressure: out_ready=0, push 6 codes -> 1 code in the output stage plus 4 in the FIFO, full=1, in_ready=0, 6th code refused; then out_ready=1 -> 5 words in order.
- Count saturation: 260 handshakes -> count=8'hFF.
- Reset mid-stream: rst pulsed with 3 codes queued -> out_valid=0, empty=1, count=0 at once; a later code 3'd2 -> out_y=8'h04.
